// File: rtl/gol_pkg.sv
// Shared definitions for the Game of Life generation sequencer.
package gol_pkg;

  localparam int GRID_W = 64;

  localparam logic [GRID_W-1:0] GOL_DEFAULT_SEED = 64'h4020_E000_0000_0000;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    EVAL,
    ACK,
    DONE
  } gol_state_t;

endpackage

// File: rtl/gol_tick_div.sv
// Inter-generation delay counter: loads a delay, counts down while enabled
// and holds at zero.
module gol_tick_div #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/gol_sequencer.sv
// Generation sequencer: owns the current grid register and decides when the
// external datapath's next generation is committed, with handshake and status.
module gol_sequencer
  import gol_pkg::*;
#(
  parameter int CNT_W  = 16,
  parameter int RATE_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [GRID_W-1:0] seed_i,
  input  logic              load_i,
  input  logic              run_i,
  input  logic              step_i,
  input  logic [CNT_W-1:0]  gen_limit_i,
  input  logic [RATE_W-1:0] rate_i,
  input  logic [GRID_W-1:0] next_grid_i,
  output logic [GRID_W-1:0] cur_grid_o,
  output logic [CNT_W-1:0]  gen_cnt_o,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              stable_o,
  output logic              extinct_o
);

  gol_state_t        state, state_nxt;
  logic [GRID_W-1:0] cur_grid;
  logic [CNT_W-1:0]  gen_cnt;
  logic              stable_q, extinct_q;
  logic              tick_load, tick_en, tick_zero;
  logic              commit, set_stable, set_extinct;

  gol_tick_div #(.W(RATE_W)) u_tick_div (
    .clk      (clk),
    .reset    (reset),
    .load     (tick_load),
    .load_val (rate_i),
    .en       (tick_en),
    .zero     (tick_zero)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    tick_load   = 1'b0;
    tick_en     = 1'b0;
    commit      = 1'b0;
    set_stable  = 1'b0;
    set_extinct = 1'b0;
    if (load_i) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (step_i) begin
            state_nxt = EVAL;
          end else if (run_i) begin
            state_nxt = WAIT;
            tick_load = 1'b1;
          end
        end
        WAIT: begin
          if (!run_i) begin
            state_nxt = IDLE;
          end else if (tick_zero) begin
            state_nxt = EVAL;
          end else begin
            tick_en = 1'b1;
          end
        end
        // An empty grid is reported as extinct even though it also equals itself.
        EVAL: begin
          if (next_grid_i == '0) begin
            commit      = 1'b1;
            set_extinct = 1'b1;
            state_nxt   = DONE;
          end else if (next_grid_i == cur_grid) begin
            set_stable = 1'b1;
            state_nxt  = DONE;
          end else begin
            commit    = 1'b1;
            state_nxt = ACK;
          end
        end
        ACK: begin
          if (out_ready_i) begin
            if ((gen_limit_i != '0) && (gen_cnt == gen_limit_i)) begin
              state_nxt = DONE;
            end else if (run_i) begin
              state_nxt = WAIT;
              tick_load = 1'b1;
            end else begin
              state_nxt = IDLE;
            end
          end
        end
        DONE: begin
          state_nxt = DONE;
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_grid  <= GOL_DEFAULT_SEED;
      gen_cnt   <= '0;
      stable_q  <= 1'b0;
      extinct_q <= 1'b0;
    end else if (load_i) begin
      cur_grid  <= seed_i;
      gen_cnt   <= '0;
      stable_q  <= 1'b0;
      extinct_q <= 1'b0;
    end else begin
      if (commit) begin
        cur_grid <= next_grid_i;
      end
      // Saturate instead of wrapping so a long free run never looks fresh.
      if (commit && (gen_cnt != '1)) begin
        gen_cnt <= gen_cnt + 1'b1;
      end
      if (set_stable) begin
        stable_q <= 1'b1;
      end
      if (set_extinct) begin
        extinct_q <= 1'b1;
      end
    end
  end

  assign cur_grid_o  = cur_grid;
  assign gen_cnt_o   = gen_cnt;
  assign stable_o    = stable_q;
  assign extinct_o   = extinct_q;
  assign out_valid_o = (state == ACK);
  assign done_o      = (state == DONE);
  assign busy_o      = (state == WAIT) || (state == EVAL) || (state == ACK);

endmodule

// File: tb/tb_gol_sequencer.sv
// Directed bench for gol_sequencer; an 8x8 bounded Life model plays the
// external datapath.
module tb_gol_sequencer;

  localparam logic [63:0] DEF_SEED = 64'h4020_E000_0000_0000;
  localparam logic [63:0] BLOCK    = 64'h0000_0018_1800_0000;
  localparam logic [63:0] BLINK_H  = 64'h0000_0000_1C00_0000;
  localparam logic [63:0] BLINK_V  = 64'h0000_0008_0808_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] seed_i;
  logic        load_i, run_i, step_i, out_ready_i;
  logic [15:0] gen_limit_i;
  logic [7:0]  rate_i;
  logic [63:0] next_grid_i, cur_grid_o;
  logic [15:0] gen_cnt_o;
  logic        out_valid_o, busy_o, done_o, stable_o, extinct_o;

  int checks   = 0;
  int failures = 0;
  int pulse_cnt = 0;
  logic valid_prev = 1'b0;

  gol_sequencer #(.CNT_W(16), .RATE_W(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .seed_i      (seed_i),
    .load_i      (load_i),
    .run_i       (run_i),
    .step_i      (step_i),
    .gen_limit_i (gen_limit_i),
    .rate_i      (rate_i),
    .next_grid_i (next_grid_i),
    .cur_grid_o  (cur_grid_o),
    .gen_cnt_o   (gen_cnt_o),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .stable_o    (stable_o),
    .extinct_o   (extinct_o)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] life(input logic [63:0] g);
    logic [63:0] n;
    int cnt;
    n = '0;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        cnt = 0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            if (!(dr == 0 && dc == 0) && (r + dr >= 0) && (r + dr < 8) &&
                (c + dc >= 0) && (c + dc < 8)) begin
              cnt += int'(g[(r + dr) * 8 + c + dc]);
            end
          end
        end
        n[r * 8 + c] = g[r * 8 + c] ? (cnt == 2 || cnt == 3) : (cnt == 3);
      end
    end
    return n;
  endfunction

  assign next_grid_i = life(cur_grid_o);

  always @(negedge clk) begin
    if (out_valid_o && !valid_prev) pulse_cnt++;
    valid_prev = out_valid_o;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic ld, input logic [63:0] sd,
                               input logic st, input logic rn);
    load_i = ld;
    seed_i = sd;
    step_i = st;
    run_i  = rn;
    tick();
    load_i = 1'b0;
    step_i = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  initial begin
    int base, t1, t2;
    logic [15:0] prev_cnt;

    reset = 1'b1; seed_i = '0; load_i = 0; run_i = 0; step_i = 0;
    out_ready_i = 1'b1; gen_limit_i = '0; rate_i = '0;
    tick(); tick();
    checkOutput("rst_grid", cur_grid_o, DEF_SEED);
    checkOutput("rst_cnt", 64'(gen_cnt_o), 64'd0);
    checkOutput("rst_flags", 64'({busy_o, done_o, stable_o, extinct_o, out_valid_o}), 64'd0);
    reset = 1'b0;
    tick();

    // Still life: equality detected, nothing committed.
    base = pulse_cnt;
    applyStimulus(1'b1, BLOCK, 1'b0, 1'b0);
    checkOutput("blk_load", cur_grid_o, BLOCK);
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    checkOutput("blk_eval_busy", 64'(busy_o), 64'd1);
    tick();
    checkOutput("blk_done", 64'(done_o), 64'd1);
    checkOutput("blk_stable", 64'(stable_o), 64'd1);
    checkOutput("blk_extinct", 64'(extinct_o), 64'd0);
    checkOutput("blk_cnt", 64'(gen_cnt_o), 64'd0);
    checkOutput("blk_grid", cur_grid_o, BLOCK);
    applyStimulus(1'b0, '0, 1'b1, 1'b1);
    tick();
    checkOutput("blk_done_hold", 64'(done_o), 64'd1);
    checkOutput("blk_no_valid", 64'(pulse_cnt - base), 64'd0);

    // Empty grid: extinct wins over stable.
    run_i = 1'b0;
    applyStimulus(1'b1, 64'd0, 1'b0, 1'b0);
    checkOutput("ext_load_clear", 64'({done_o, stable_o}), 64'd0);
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    tick();
    checkOutput("ext_extinct", 64'(extinct_o), 64'd1);
    checkOutput("ext_stable", 64'(stable_o), 64'd0);
    checkOutput("ext_done", 64'(done_o), 64'd1);
    checkOutput("ext_cnt", 64'(gen_cnt_o), 64'd1);

    // Free run with generation limit.
    gen_limit_i = 16'd5;
    out_ready_i = 1'b1;
    applyStimulus(1'b1, BLINK_H, 1'b0, 1'b0);
    base = pulse_cnt;
    run_i = 1'b1;
    for (int i = 0; i < 200 && !done_o; i++) tick();
    checkOutput("lim_done", 64'(done_o), 64'd1);
    checkOutput("lim_cnt", 64'(gen_cnt_o), 64'd5);
    checkOutput("lim_pulses", 64'(pulse_cnt - base), 64'd5);
    checkOutput("lim_stable", 64'(stable_o), 64'd0);
    checkOutput("lim_grid", cur_grid_o, BLINK_V);
    tick(); tick(); tick();
    checkOutput("lim_hold_cnt", 64'(gen_cnt_o), 64'd5);
    run_i = 1'b0;

    // Rate 3: commits spaced six cycles apart.
    gen_limit_i = '0;
    rate_i = 8'd3;
    applyStimulus(1'b1, BLINK_H, 1'b0, 1'b0);
    run_i = 1'b1;
    prev_cnt = gen_cnt_o;
    t1 = -1; t2 = -1;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (gen_cnt_o != prev_cnt) begin
        if (t1 < 0 && prev_cnt >= 16'd1) t1 = i;
        else if (t1 >= 0 && t2 < 0) t2 = i;
      end
      prev_cnt = gen_cnt_o;
    end
    checkOutput("rate_found", 64'(t2 >= 0), 64'd1);
    checkOutput("rate_gap", 64'(t2 - t1), 64'd6);
    run_i = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    checkOutput("rate_stop_busy", 64'(busy_o), 64'd0);

    // Backpressure in ACK.
    out_ready_i = 1'b0;
    rate_i = '0;
    applyStimulus(1'b1, BLINK_H, 1'b0, 1'b0);
    base = pulse_cnt;
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    checkOutput("bp_eval_valid", 64'(out_valid_o), 64'd0);
    tick();
    checkOutput("bp_valid", 64'(out_valid_o), 64'd1);
    checkOutput("bp_grid", cur_grid_o, BLINK_V);
    checkOutput("bp_cnt", 64'(gen_cnt_o), 64'd1);
    for (int i = 0; i < 10; i++) begin
      tick();
      checkOutput("bp_hold_valid", 64'(out_valid_o), 64'd1);
      checkOutput("bp_hold_grid", cur_grid_o, BLINK_V);
      checkOutput("bp_hold_cnt", 64'(gen_cnt_o), 64'd1);
    end
    out_ready_i = 1'b1;
    tick();
    checkOutput("bp_release_valid", 64'(out_valid_o), 64'd0);
    checkOutput("bp_release_cnt", 64'(gen_cnt_o), 64'd1);
    checkOutput("bp_pulses", 64'(pulse_cnt - base), 64'd1);

    // Load beats step while waiting.
    rate_i = 8'd10;
    run_i = 1'b1;
    tick(); tick(); tick();
    checkOutput("ld_wait_busy", 64'(busy_o), 64'd1);
    applyStimulus(1'b1, BLOCK, 1'b1, 1'b1);
    checkOutput("ld_idle", 64'(busy_o), 64'd0);
    checkOutput("ld_grid", cur_grid_o, BLOCK);
    checkOutput("ld_cnt", 64'(gen_cnt_o), 64'd0);
    checkOutput("ld_valid", 64'(out_valid_o), 64'd0);
    run_i = 1'b0;
    tick(); tick();

    // Asynchronous reset while stalled in ACK.
    out_ready_i = 1'b0;
    rate_i = '0;
    applyStimulus(1'b1, BLINK_H, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    tick();
    checkOutput("ar_in_ack", 64'(out_valid_o), 64'd1);
    #2 reset = 1'b1;
    #1;
    checkOutput("ar_grid", cur_grid_o, DEF_SEED);
    checkOutput("ar_cnt", 64'(gen_cnt_o), 64'd0);
    checkOutput("ar_valid", 64'(out_valid_o), 64'd0);
    tick();
    reset = 1'b0;
    out_ready_i = 1'b1;
    tick();
    checkOutput("ar_after_grid", cur_grid_o, DEF_SEED);
    checkOutput("ar_after_busy", 64'(busy_o), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
